// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, drives the imem request/ack
// handshake and presents one instruction at a time to IF/ID via a one-entry skid.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ce,
    output logic [31:0] pc,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

    state_t      state, state_nx;
    logic [31:0] skid, skid_pc;
    logic [31:0] pc_nx, mem_addr_nx, inst_pc_nx, inst_nx, skid_nx, skid_pc_nx;
    logic        mem_req_nx, inst_valid_nx, ce_nx;
    logic        redir, slot_free;
    logic [31:0] tgt, pc_inc;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

    // flush outranks branch; a simultaneous branch is ignored entirely
    assign redir     = flush | branch_flag;
    assign tgt       = align_word(flush ? new_pc : branch_target);
    assign slot_free = !inst_valid || !stall;
    assign pc_inc    = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = FETCH;
            FETCH: begin
                if (redir)
                    state_nx = mem_ack ? FETCH : DISCARD;
                else if (mem_ack && !slot_free)
                    state_nx = HOLD;
            end
            HOLD:    if (redir || !stall) state_nx = FETCH;
            DISCARD: if (mem_ack) state_nx = FETCH;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pc_nx         = pc;
        mem_req_nx    = mem_req;
        mem_addr_nx   = mem_addr;
        inst_valid_nx = inst_valid;
        inst_pc_nx    = inst_pc;
        inst_nx       = inst;
        skid_nx       = skid;
        skid_pc_nx    = skid_pc;
        ce_nx         = (state_nx != IDLE);
        case (state)
            IDLE: begin
                mem_req_nx  = 1'b1;
                pc_nx       = redir ? tgt : pc;
                mem_addr_nx = redir ? tgt : pc;
            end
            FETCH: begin
                if (redir) begin
                    // an unacked request cannot be withdrawn, so mem_addr holds
                    inst_valid_nx = 1'b0;
                    pc_nx         = tgt;
                    if (mem_ack) mem_addr_nx = tgt;
                end else if (mem_ack && slot_free) begin
                    inst_valid_nx = 1'b1;
                    inst_nx       = mem_rdata;
                    inst_pc_nx    = mem_addr;
                    pc_nx         = pc_inc;
                    mem_addr_nx   = pc_inc;
                end else if (mem_ack) begin
                    skid_nx    = mem_rdata;
                    skid_pc_nx = mem_addr;
                    pc_nx      = pc_inc;
                    mem_req_nx = 1'b0;
                end else if (!stall) begin
                    inst_valid_nx = 1'b0;
                end
            end
            HOLD: begin
                if (redir) begin
                    inst_valid_nx = 1'b0;
                    pc_nx         = tgt;
                    mem_req_nx    = 1'b1;
                    mem_addr_nx   = tgt;
                end else if (!stall) begin
                    inst_valid_nx = 1'b1;
                    inst_nx       = skid;
                    inst_pc_nx    = skid_pc;
                    mem_req_nx    = 1'b1;
                    mem_addr_nx   = pc;
                end
            end
            DISCARD: begin
                inst_valid_nx = 1'b0;
                if (redir) pc_nx = tgt;
                if (mem_ack) mem_addr_nx = redir ? tgt : pc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ce         <= 1'b0;
            pc         <= RESET_PC;
            mem_req    <= 1'b0;
            mem_addr   <= RESET_PC;
            inst_valid <= 1'b0;
            inst_pc    <= 32'd0;
            inst       <= 32'd0;
            skid       <= 32'd0;
            skid_pc    <= 32'd0;
        end else begin
            ce         <= ce_nx;
            pc         <= pc_nx;
            mem_req    <= mem_req_nx;
            mem_addr   <= mem_addr_nx;
            inst_valid <= inst_valid_nx;
            inst_pc    <= inst_pc_nx;
            inst       <= inst_nx;
            skid       <= skid_nx;
            skid_pc    <= skid_pc_nx;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed cycle table for the corner cases, then a
// random run scored against the program-order instruction stream.
module tb_if_fetch_ctrl;

    localparam logic [31:0] K = 32'hA5A5A5A5;
    localparam logic [31:0] RESET_PC = 32'h00000000;

    logic        clk, rst, stall, flush, branch_flag, mem_ack;
    logic [31:0] new_pc, branch_target;
    logic        mem_req, ce, inst_valid;
    logic [31:0] mem_addr, mem_rdata, pc, inst_pc, inst;

    assign mem_rdata = mem_addr ^ K;

    if_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .ce(ce), .pc(pc), .inst_valid(inst_valid),
        .inst_pc(inst_pc), .inst(inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, ack, fl;
        logic [31:0] npc;
        logic        br;
        logic [31:0] btgt;
        logic        ce, req;
        logic [31:0] addr, pc;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;

    vec_t tbl [31];
    int nchk = 0;
    int nerr = 0;

    function automatic vec_t v(input logic r, s, a, f, input logic [31:0] np,
                               input logic b, input logic [31:0] bt,
                               input logic c, q, input logic [31:0] ad, p,
                               input logic i, input logic [31:0] ip);
        vec_t t;
        t.rst = r; t.stall = s; t.ack = a; t.fl = f; t.npc = np; t.br = b; t.btgt = bt;
        t.ce = c; t.req = q; t.addr = ad; t.pc = p; t.iv = i; t.ipc = ip;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    logic [31:0] exp_pc;
    int          nacc, lat;
    logic        pend, r;
    logic        p_valid, p_req, p_ack, p_rst, p_iv, p_stall, p_redir;
    logic [31:0] p_addr, p_ipc, p_inst;

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_flag = 1'b0; mem_ack = 1'b0;
        new_pc = 32'd0; branch_target = 32'd0;

        // reset, startup, skid stall, redirect during wait, priority/alignment, wrap, reset in HOLD/DISCARD
        tbl[0]  = v(1,0,0,0,0,0,0,            0,0,0,0,0,0);
        tbl[1]  = v(1,0,0,0,0,0,0,            0,0,0,0,0,0);
        tbl[2]  = v(1,0,0,0,0,0,0,            0,0,0,0,0,0);
        tbl[3]  = v(0,0,0,0,0,0,0,            1,1,0,0,0,0);
        tbl[4]  = v(0,0,1,0,0,0,0,            1,1,4,4,1,0);
        tbl[5]  = v(0,0,1,0,0,0,0,            1,1,8,8,1,4);
        tbl[6]  = v(0,1,1,0,0,0,0,            1,0,8,12,1,4);
        tbl[7]  = v(0,1,1,0,0,0,0,            1,0,8,12,1,4);
        tbl[8]  = v(0,1,0,0,0,0,0,            1,0,8,12,1,4);
        tbl[9]  = v(0,1,0,0,0,0,0,            1,0,8,12,1,4);
        tbl[10] = v(0,0,0,0,0,0,0,            1,1,12,12,1,8);
        tbl[11] = v(0,0,1,0,0,0,0,            1,1,16,16,1,12);
        tbl[12] = v(0,0,0,0,0,1,32'h100,      1,1,16,32'h100,0,0);
        tbl[13] = v(0,0,0,0,0,0,0,            1,1,16,32'h100,0,0);
        tbl[14] = v(0,0,0,0,0,0,0,            1,1,16,32'h100,0,0);
        tbl[15] = v(0,0,1,0,0,0,0,            1,1,32'h100,32'h100,0,0);
        tbl[16] = v(0,0,1,0,0,0,0,            1,1,32'h104,32'h104,1,32'h100);
        tbl[17] = v(0,0,1,1,32'h200,1,32'h300,1,1,32'h200,32'h200,0,0);
        tbl[18] = v(0,0,1,0,0,0,0,            1,1,32'h204,32'h204,1,32'h200);
        tbl[19] = v(0,0,1,0,0,1,32'h303,      1,1,32'h300,32'h300,0,0);
        tbl[20] = v(0,0,1,0,0,0,0,            1,1,32'h304,32'h304,1,32'h300);
        tbl[21] = v(0,0,1,0,0,1,32'hFFFFFFFC, 1,1,32'hFFFFFFFC,32'hFFFFFFFC,0,0);
        tbl[22] = v(0,0,1,0,0,0,0,            1,1,0,0,1,32'hFFFFFFFC);
        tbl[23] = v(0,0,1,0,0,0,0,            1,1,4,4,1,0);
        tbl[24] = v(0,1,1,0,0,0,0,            1,0,4,8,1,0);
        tbl[25] = v(1,1,0,0,0,0,0,            0,0,0,0,0,0);
        tbl[26] = v(0,0,1,0,0,0,0,            1,1,0,0,0,0);
        tbl[27] = v(0,0,0,0,0,1,32'h40,       1,1,0,32'h40,0,0);
        tbl[28] = v(1,0,0,0,0,0,0,            0,0,0,0,0,0);
        tbl[29] = v(0,0,1,0,0,0,0,            1,1,0,0,0,0);
        tbl[30] = v(0,0,1,0,0,0,0,            1,1,4,4,1,0);

        for (int i = 0; i < 31; i++) begin
            rst = tbl[i].rst; stall = tbl[i].stall; mem_ack = tbl[i].ack;
            flush = tbl[i].fl; new_pc = tbl[i].npc;
            branch_flag = tbl[i].br; branch_target = tbl[i].btgt;
            @(negedge clk);
            chk($sformatf("row%0d_ce", i), {31'd0, ce}, {31'd0, tbl[i].ce});
            chk($sformatf("row%0d_req", i), {31'd0, mem_req}, {31'd0, tbl[i].req});
            chk($sformatf("row%0d_addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("row%0d_pc", i), pc, tbl[i].pc);
            chk($sformatf("row%0d_iv", i), {31'd0, inst_valid}, {31'd0, tbl[i].iv});
            if (tbl[i].iv) begin
                chk($sformatf("row%0d_ipc", i), inst_pc, tbl[i].ipc);
                chk($sformatf("row%0d_inst", i), inst, tbl[i].ipc ^ K);
            end
        end

        // random phase: every accepted instruction must follow program order
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_flag = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = RESET_PC; nacc = 0; pend = 1'b0; lat = 0; p_valid = 1'b0;
        p_req = 0; p_ack = 0; p_rst = 0; p_iv = 0; p_stall = 0; p_redir = 0;
        p_addr = 0; p_ipc = 0; p_inst = 0;

        for (int c = 0; c < 4000; c++) begin
            if (p_valid) begin
                if (p_req && !p_ack && !p_rst) begin
                    chk("addr_hold", mem_addr, p_addr);
                    chk("req_hold", {31'd0, mem_req}, 32'd1);
                end
                if (p_iv && p_stall && !p_redir && !p_rst) begin
                    chk("stall_iv", {31'd0, inst_valid}, 32'd1);
                    chk("stall_ipc", inst_pc, p_ipc);
                    chk("stall_inst", inst, p_inst);
                end
                if (p_rst) begin
                    chk("rst_req", {31'd0, mem_req}, 32'd0);
                    chk("rst_ce", {31'd0, ce}, 32'd0);
                    chk("rst_iv", {31'd0, inst_valid}, 32'd0);
                    chk("rst_pc", pc, RESET_PC);
                end
            end

            r = ($urandom_range(0, 599) == 0);
            rst = r;
            stall = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 39) == 0);
            branch_flag = ($urandom_range(0, 19) == 0);
            new_pc = $urandom;
            branch_target = $urandom;
            if (!mem_req) begin
                pend = 1'b0;
                mem_ack = 1'b0;
            end else begin
                if (!pend) begin
                    pend = 1'b1;
                    lat = $urandom_range(0, 2);
                end
                if (lat == 0) begin
                    mem_ack = 1'b1;
                    pend = 1'b0;
                end else begin
                    mem_ack = 1'b0;
                    lat--;
                end
            end

            if (r) begin
                exp_pc = RESET_PC;
            end else begin
                if (inst_valid && !stall) begin
                    chk("accept_pc", inst_pc, exp_pc);
                    chk("accept_inst", inst, exp_pc ^ K);
                    exp_pc = exp_pc + 32'd4;
                    nacc++;
                end
                if (flush) exp_pc = new_pc & ~32'd3;
                else if (branch_flag) exp_pc = branch_target & ~32'd3;
            end

            p_valid = 1'b1; p_req = mem_req; p_ack = mem_ack; p_rst = r;
            p_iv = inst_valid; p_stall = stall; p_redir = flush | branch_flag;
            p_addr = mem_addr; p_ipc = inst_pc; p_inst = inst;
            @(negedge clk);
        end

        chk("accept_count_ok", {31'd0, (nacc >= 300)}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller for the CPU front end. It owns the fetch PC and the instruction-memory request/acknowledge handshake, and presents one fetched instruction at a time to the IF/ID stage. It handles back-pressure through a one-entry skid buffer, and handles control-flow redirects (exception flush, branch) including redirects that arrive while a memory request is still outstanding.

## Interface
Parameters:
- RESET_PC, 32'h00000000, fetch address loaded on reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  IF/ID cannot accept; `inst_valid` and its payload must hold
- flush  in  1  exception redirect pulse; highest priority
- new_pc  in  32  flush target
- branch_flag  in  1  branch redirect pulse
- branch_target  in  32  branch target
- mem_req  out  1  instruction-memory request
- mem_addr  out  32  request address; stable while `mem_req`=1 and no `mem_ack`
- mem_ack  in  1  response valid this cycle; only meaningful while `mem_req`=1
- mem_rdata  in  32  instruction word, valid with `mem_ack`
- ce  out  1  fetch enabled; 0 only in IDLE
- pc  out  32  next address to fetch
- inst_valid  out  1  `inst`/`inst_pc` hold an instruction for IF/ID
- inst_pc  out  32  address of `inst`
- inst  out  32  instruction word

## Operation
- All outputs are registered.
- **Reset values:**
  - state = IDLE
  - ce = 0, pc = RESET_PC
  - mem_req = 0, mem_addr = RESET_PC
  - inst_valid = 0, inst_pc = 0, inst = 0
  - skid buffer empty
- **Redirect target selection:**
  - flush → `new_pc`; else branch_flag → `branch_target`.
  - Bits [1:0] of the target are forced to 0.
  - Sequential next PC = pc + 4, modulo 2^32 (32'hFFFFFFFC → 0).
- **Output slot "free"** means `inst_valid`=0 or `stall`=0 in the current cycle.
- **IDLE:**
  - Next edge goes to FETCH with ce=1, mem_req=1, mem_addr=pc.
  - A redirect in this cycle sets pc and mem_addr to the target instead.
- **FETCH** (mem_req=1):
  - No ack: hold mem_addr; the output slot drains when `stall`=0.
  - Ack, slot free: load inst/inst_pc=mem_rdata/mem_addr, inst_valid=1. Set pc and mem_addr to pc+4 and stay in FETCH. This gives back-to-back requests, one per cycle with single-cycle memory.
  - Ack, slot occupied and stall=1: capture the word into the skid buffer, drop mem_req, go to HOLD.
- **HOLD** (mem_req=0):
  - On stall=0: the output takes the skid entry, the skid empties, mem_req=1 with mem_addr=pc, go to FETCH.
- **Redirect in FETCH or HOLD:**
  - Clear inst_valid and the skid buffer; pc = target.
  - FETCH without ack: keep mem_req=1 and the old mem_addr (the request cannot be withdrawn), go to DISCARD.
  - FETCH with ack, or HOLD: drop any returned data; next edge has mem_req=1, mem_addr=target, state FETCH.
- **DISCARD** (mem_req=1, old address):
  - inst_valid stays 0.
  - On ack: drop the data, mem_addr=pc, go to FETCH.
  - A further redirect updates pc (latest wins). If it coincides with the ack, the newest target is used.
- flush and branch_flag in the same cycle: flush wins, and the branch is ignored entirely.
- rst overrides everything mid-operation and returns to the reset values next edge. Any outstanding memory response is ignored, because mem_req=0 after reset.

## Timing
- First request: mem_req rises at the first edge with rst=0 (IDLE → FETCH).
- Fetch latency: `inst_valid` rises at the edge after the `mem_ack` cycle.
- Throughput: 1 instruction/cycle with zero-wait memory and no stall.
- Redirect-to-request latency:
  - 1 cycle when no request is outstanding, or when the ack coincides with the redirect.
  - Otherwise 1 cycle after the outstanding ack.
- No instruction from before a redirect ever reaches `inst_valid`=1 after the redirect cycle.
- Stall: `inst`/`inst_pc`/`inst_valid` are bit-for-bit stable while `stall`=1.

## Test plan
- **Reset/startup:** hold rst 3 cycles, then release; memory acks every cycle with rdata = addr ^ 32'hA5A5A5A5.
  - Required: ce=0 and mem_req=0 during reset.
  - Required: mem_addr sequence 0, 4, 8, …; inst_valid rises 2 edges after release with inst_pc=0.
- **Stall with skid:** assert stall for 4 cycles while acks arrive.
  - Required: one word is captured into the skid buffer and the FSM enters HOLD with mem_req=0.
  - Required: on release, inst_pc values continue contiguously, with none lost or duplicated.
- **Redirect with outstanding request:** memory waits 3 cycles; branch_flag=1 with branch_target=32'h100 in wait cycle 1.
  - Required: mem_addr holds the old address until the ack, and that data is discarded.
  - Required: the next request goes to 32'h100, and the first valid inst_pc is 32'h100.
- **Priority and alignment:** flush (new_pc=32'h200) and branch (32'h300) in the same cycle → the fetch goes to 32'h200. A branch_target of 32'h303 → fetch address 32'h300.
- **Wrap-around:** branch to 32'hFFFFFFFC → the next sequential mem_addr is 32'h00000000.
- **Reset mid-operation:** assert rst in HOLD and in DISCARD.
  - Required: all outputs return to reset values at the next edge.
  - Required: a late mem_ack is ignored, and fetch restarts at RESET_PC.
